// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives data_path strobes for one register-register ALU instruction (Y load, ALU into Z, Z writeback, LO/HI for MUL/DIV).
// Latency: all outputs registered; an instruction holds busy for 3 (unary/immediate), 4 (binary) or 5 (MUL/DIV) cycles, done in the last one.
// Backpressure: none; start is only sampled in IDLE. Define ALU_SEQ_IMM_LOAD_EN to enable the Mdatain immediate-load path.
module alu_op_sequencer #(
  parameter logic [4:0] OP_NOT = 5'b01001,
  parameter logic [4:0] OP_NEG = 5'b01000,
  parameter logic [4:0] OP_MUL = 5'b01111,
  parameter logic [4:0] OP_DIV = 5'b10000
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  op_in,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  rc,
  input  logic        imm_req,
  output logic [4:0]  op,
  output logic [15:0] r_out,
  output logic [15:0] r_in,
  output logic        Yin,
  output logic        ZHighin,
  output logic        Zlowin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef ALU_SEQ_IMM_LOAD_EN
  typedef enum logic [2:0] {IDLE, S_Y, S_Z, S_WB, S_WBH, S_RD, S_MW, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, S_Y, S_Z, S_WB, S_WBH, DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [3:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic        accept, err_d, wide_d;

  logic [4:0]  op_o_d;
  logic [15:0] r_out_d, r_in_d;
  logic        yin_d, zhighin_d, zlowin_d, zhighout_d, zlowout_d;
  logic        hiin_d, loin_d, mdrin_d, mdrout_d, read_d, busy_d, done_d;

  // Next state and field latch; fields are captured only when a request is accepted.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    accept  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op_in == OP_NOT || op_in == OP_NEG) begin
            accept  = 1'b1;
            state_d = S_Z;
          end else if (imm_req) begin
`ifdef ALU_SEQ_IMM_LOAD_EN
            accept  = 1'b1;
            state_d = S_RD;
`else
            err_d   = 1'b1;
`endif
          end else begin
            accept  = 1'b1;
            state_d = S_Y;
          end
        end
      end
      S_Y:   state_d = S_Z;
      S_Z:   state_d = S_WB;
      S_WB:  state_d = (op_q == OP_MUL || op_q == OP_DIV) ? S_WBH : DONE;
      S_WBH: state_d = DONE;
`ifdef ALU_SEQ_IMM_LOAD_EN
      S_RD:  state_d = S_MW;
      S_MW:  state_d = DONE;
`endif
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      op_d = op_in;
      ra_d = ra;
      rb_d = rb;
      rc_d = rc;
    end
  end

  // Strobe decode for the state being entered, so the flops below present them in that state.
  always_comb begin
    wide_d     = (op_d == OP_MUL) || (op_d == OP_DIV);
    r_out_d    = '0;
    r_in_d     = '0;
    yin_d      = 1'b0;
    zhighin_d  = 1'b0;
    zlowin_d   = 1'b0;
    zhighout_d = 1'b0;
    zlowout_d  = 1'b0;
    hiin_d     = 1'b0;
    loin_d     = 1'b0;
    mdrin_d    = 1'b0;
    mdrout_d   = 1'b0;
    read_d     = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      S_Y: begin
        r_out_d = 16'd1 << rb_d;
        yin_d   = 1'b1;
      end
      S_Z: begin
        r_out_d   = 16'd1 << rc_d;
        zlowin_d  = 1'b1;
        zhighin_d = wide_d;
      end
      S_WB: begin
        zlowout_d = 1'b1;
        if (wide_d) loin_d = 1'b1;
        else        r_in_d = 16'd1 << ra_d;
      end
      S_WBH: begin
        zhighout_d = 1'b1;
        hiin_d     = 1'b1;
      end
`ifdef ALU_SEQ_IMM_LOAD_EN
      S_RD: begin
        read_d  = 1'b1;
        mdrin_d = 1'b1;
      end
      S_MW: begin
        mdrout_d = 1'b1;
        r_in_d   = 16'd1 << ra_d;
      end
`endif
      DONE:    done_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    op_o_d = busy_d ? op_d : 5'd0;
  end

  // State, latched fields and registered outputs; clear aborts everything immediately.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q  <= IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      op       <= '0;
      r_out    <= '0;
      r_in     <= '0;
      Yin      <= 1'b0;
      ZHighin  <= 1'b0;
      Zlowin   <= 1'b0;
      Zhighout <= 1'b0;
      Zlowout  <= 1'b0;
      HIin     <= 1'b0;
      LOin     <= 1'b0;
      MDRin    <= 1'b0;
      MDRout   <= 1'b0;
      Read     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
      op       <= op_o_d;
      r_out    <= r_out_d;
      r_in     <= r_in_d;
      Yin      <= yin_d;
      ZHighin  <= zhighin_d;
      Zlowin   <= zlowin_d;
      Zhighout <= zhighout_d;
      Zlowout  <= zlowout_d;
      HIin     <= hiin_d;
      LOin     <= loin_d;
      MDRin    <= mdrin_d;
      MDRout   <= mdrout_d;
      Read     <= read_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench for alu_op_sequencer with a per-cycle expected-output queue.
// Expected output vectors are pushed when a request is driven and popped one per cycle.
// Build with or without ALU_SEQ_IMM_LOAD_EN; the immediate-load expectations follow the macro.
module tb_alu_op_sequencer;
  localparam logic [4:0] OP_NOT = 5'b01001;
  localparam logic [4:0] OP_NEG = 5'b01000;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  typedef struct packed {
    logic [4:0]  op;
    logic [15:0] r_out;
    logic [15:0] r_in;
    logic yin, zhighin, zlowin, zhighout, zlowout, hiin, loin;
    logic mdrin, mdrout, rd, busy, done, err;
  } obs_t;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic        imm_req = 1'b0;
  logic [4:0]  op_in = '0;
  logic [3:0]  ra = '0, rb = '0, rc = '0;
  logic [4:0]  op;
  logic [15:0] r_out, r_in;
  logic Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin, MDRin, MDRout, Read, busy, done, err;

  obs_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  alu_op_sequencer dut (
    .Clock(Clock), .clear(clear), .start(start), .op_in(op_in),
    .ra(ra), .rb(rb), .rc(rc), .imm_req(imm_req),
    .op(op), .r_out(r_out), .r_in(r_in),
    .Yin(Yin), .ZHighin(ZHighin), .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIin(HIin), .LOin(LOin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read),
    .busy(busy), .done(done), .err(err)
  );

  always #5 Clock = ~Clock;

  function automatic obs_t observed();
    obs_t v;
    v.op = op; v.r_out = r_out; v.r_in = r_in;
    v.yin = Yin; v.zhighin = ZHighin; v.zlowin = Zlowin; v.zhighout = Zhighout;
    v.zlowout = Zlowout; v.hiin = HIin; v.loin = LOin; v.mdrin = MDRin;
    v.mdrout = MDRout; v.rd = Read; v.busy = busy; v.done = done; v.err = err;
    return v;
  endfunction

  task automatic check(input string tag, input obs_t expv);
    obs_t got;
    got = observed();
    compared++;
    assert (got === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  // Expected busy cycles of one instruction, followed by the idle cycle after it.
  task automatic push_instr(input logic [4:0] o, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic imm);
    obs_t v;
    logic wide;
    wide = (o == OP_MUL) || (o == OP_DIV);
    if (o == OP_NOT || o == OP_NEG) begin
      v = '0; v.op = o; v.busy = 1'b1; v.r_out = 16'd1 << c; v.zlowin = 1'b1; exp_q.push_back(v);
      v = '0; v.op = o; v.busy = 1'b1; v.zlowout = 1'b1; v.r_in = 16'd1 << a; exp_q.push_back(v);
    end else if (imm) begin
`ifdef ALU_SEQ_IMM_LOAD_EN
      v = '0; v.op = o; v.busy = 1'b1; v.rd = 1'b1; v.mdrin = 1'b1; exp_q.push_back(v);
      v = '0; v.op = o; v.busy = 1'b1; v.mdrout = 1'b1; v.r_in = 16'd1 << a; exp_q.push_back(v);
`else
      v = '0; v.err = 1'b1; exp_q.push_back(v);
      v = '0; exp_q.push_back(v);
      return;
`endif
    end else begin
      v = '0; v.op = o; v.busy = 1'b1; v.r_out = 16'd1 << b; v.yin = 1'b1; exp_q.push_back(v);
      v = '0; v.op = o; v.busy = 1'b1; v.r_out = 16'd1 << c; v.zlowin = 1'b1; v.zhighin = wide;
      exp_q.push_back(v);
      v = '0; v.op = o; v.busy = 1'b1; v.zlowout = 1'b1;
      if (wide) v.loin = 1'b1; else v.r_in = 16'd1 << a;
      exp_q.push_back(v);
      if (wide) begin
        v = '0; v.op = o; v.busy = 1'b1; v.zhighout = 1'b1; v.hiin = 1'b1; exp_q.push_back(v);
      end
    end
    v = '0; v.op = o; v.busy = 1'b1; v.done = 1'b1; exp_q.push_back(v);
    v = '0; exp_q.push_back(v);
  endtask

  // One request; with hold=1 start stays high (with scrambled fields) until the idle cycle.
  task automatic run(input string tag, input logic [4:0] o, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] c, input logic imm, input bit hold);
    @(negedge Clock);
    op_in = o; ra = a; rb = b; rc = c; imm_req = imm; start = 1'b1;
    push_instr(o, a, b, c, imm);
    while (exp_q.size() > 0) begin
      @(negedge Clock);
      check(tag, exp_q.pop_front());
      if (hold && exp_q.size() > 0) begin
        start = 1'b1;
        op_in = 5'($urandom); ra = 4'($urandom); rb = 4'($urandom);
        rc = 4'($urandom); imm_req = 1'($urandom);
      end else begin
        start = 1'b0;
        imm_req = 1'b0;
      end
    end
  endtask

  initial begin
    obs_t zero;
    zero = '0;

    // Power-on reset
    #3 clear = 1'b0;
    #3 check("reset_state", zero);
    repeat (2) @(negedge Clock);
    clear = 1'b1;

    run("binary_00101", 5'b00101, 4'd3, 4'd2, 4'd4, 1'b0, 1'b0);
    run("unary_not", OP_NOT, 4'd1, 4'd0, 4'd7, 1'b0, 1'b0);
    run("unary_neg_alias", OP_NEG, 4'd9, 4'd9, 4'd9, 1'b0, 1'b0);
    run("mul", OP_MUL, 4'd2, 4'd5, 4'd6, 1'b0, 1'b0);
    run("div_alias", OP_DIV, 4'd15, 4'd15, 4'd15, 1'b0, 1'b0);
    run("binary_alias", 5'b00011, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    run("start_held", 5'b00110, 4'd11, 4'd12, 4'd13, 1'b0, 1'b1);
    run("imm_load", 5'b00000, 4'd7, 4'd1, 4'd2, 1'b1, 1'b0);
    run("unary_over_imm", OP_NOT, 4'd4, 4'd3, 4'd5, 1'b1, 1'b0);

    // Abort in S_Z: strobes must fall without waiting for a clock edge
    @(negedge Clock);
    op_in = 5'b00101; ra = 4'd3; rb = 4'd2; rc = 4'd4; imm_req = 1'b0; start = 1'b1;
    push_instr(5'b00101, 4'd3, 4'd2, 4'd4, 1'b0);
    @(negedge Clock);
    start = 1'b0;
    check("abort_pre_y", exp_q.pop_front());
    @(negedge Clock);
    check("abort_pre_z", exp_q.pop_front());
    exp_q.delete();
    #2 clear = 1'b0;
    #1 check("abort_async", zero);
    @(negedge Clock);
    check("abort_held", zero);
    clear = 1'b1;
    run("after_abort", 5'b00101, 4'd3, 4'd2, 4'd4, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
